// File: rtl/mul8_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller.
// One partial product is folded in per cycle through a single WIDTH-bit ripple-carry row
// built from full-adder cells. Latency is fixed at WIDTH RUN cycles regardless of operands.
module mul8_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 out_valid_q, out_valid_d;

    // Shared adder row: acc_hi + (acc_lo[0] ? mcand : 0), cin tied low.
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH:0]       carry;
    logic [2*WIDTH-1:0]   shifted;

    assign addend   = acc_lo_q[0] ? mcand_q : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = acc_hi_q[i] ^ addend[i] ^ carry[i];
        assign carry[i+1]   = (acc_hi_q[i] & addend[i]) | (carry[i] & (acc_hi_q[i] ^ addend[i]));
    end

    // Carry-out becomes the new MSB so no bit of the partial sum is ever lost.
    assign shifted = {carry[WIDTH], sum, acc_lo_q[WIDTH-1:1]};

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_hi_d = shifted[2*WIDTH-1:WIDTH];
                acc_lo_d = shifted[WIDTH-1:0];
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    product_d   = shifted;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                // Product is held; only the output handshake can leave DONE.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset also aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = (state_q == StIdle) && rst_n;
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Scoreboard bench for mul8_seq_ctrl: expected products are queued on accept and popped by
// a monitor whenever an output handshake is about to complete.
module tb_mul8_seq_ctrl;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int unsigned    n_vec = 0;
    int unsigned    n_err = 0;
    int unsigned    cyc = 0;
    int unsigned    acc_cyc = 0;
    logic [2*W-1:0] exp_q[$];

    mul8_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    // Pops one expected product per completed output handshake.
    task automatic monitor();
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard_extra: got product 0x%0h, required no output", product);
                end else begin
                    e = exp_q.pop_front();
                    check("product", 32'(product), 32'(e));
                end
            end
        end
    endtask

    // Offers a/b until accepted; returns positioned 1 time unit after the accept edge.
    task automatic accept_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [2*W-1:0] exp, input bit push,
                             input bit rnd_ready, input bit hold_valid);
        bit ok;
        ok       = 1'b0;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                if (push) exp_q.push_back(exp);
            end
            @(posedge clk);
            #1;
        end
        acc_cyc = cyc;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept in 100 cycles, required accept");
        end
        if (!hold_valid) in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Follows one operation from accept to return to IDLE, scrambling a/b throughout.
    task automatic run_watch(output int lat, output int busy_n, output int rdy_n);
        bit seen;
        bit was_busy;
        seen   = 1'b0;
        lat    = 1;
        busy_n = 0;
        rdy_n  = 0;
        for (int t = 0; t < 40; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            was_busy = (busy === 1'b1);
            if (was_busy) begin
                busy_n++;
                if (in_ready !== 1'b0) rdy_n++;
            end
            @(posedge clk);
            #1;
            if (!seen) lat++;
            if (!was_busy) break;
        end
    endtask

    logic [W-1:0]   ta[5]  = '{8'd13, 8'd255, 8'd255, 8'd1, 8'd0};
    logic [W-1:0]   tb_[5] = '{8'd11, 8'd255, 8'd1, 8'd255, 8'hA5};
    logic [2*W-1:0] te[5]  = '{16'h008F, 16'hFE01, 16'h00FF, 16'h00FF, 16'h0000};

    initial begin
        int lat, busy_n, rdy_n;
        int unsigned prev_acc;
        logic [W-1:0] va, vb;
        logic [2*W-1:0] m;

        fork
            monitor();
        join_none

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors with out_ready tied high: latency, busy window, in_ready low.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept_op(ta[i], tb_[i], te[i], 1'b1, 1'b0, 1'b0);
            run_watch(lat, busy_n, rdy_n);
            check("latency", 32'(lat), 32'd9);
            check("busy_cycles", 32'(busy_n), 32'd9);
            check("in_ready_while_busy", 32'(rdy_n), 32'd0);
        end

        // Backpressure: 200*3 held while out_ready is low; in_valid pulses are ignored.
        out_ready = 1'b0;
        accept_op(8'd200, 8'd3, 16'h0258, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_product", 32'(product), 32'h0258);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        check("bp_product_kept", 32'(product), 32'h0258);
        @(posedge clk);
        #1;

        // Reset mid-RUN aborts 100*100 with no output, then 7*6 runs normally.
        accept_op(8'd100, 8'd100, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        accept_op(8'd7, 8'd6, 16'h002A, 1'b1, 1'b0, 1'b0);
        run_watch(lat, busy_n, rdy_n);
        check("latency_after_abort", 32'(lat), 32'd9);

        // Back-to-back: in_valid held high, random out_ready, spacing >= 10 cycles.
        prev_acc = 0;
        for (int i = 0; i < 300; i++) begin
            va = W'($urandom);
            vb = W'($urandom);
            m  = {8'h00, va} * {8'h00, vb};
            accept_op(va, vb, m, 1'b1, 1'b1, 1'b1);
            if (i > 0) begin
                n_vec++;
                if (acc_cyc - prev_acc < 10) begin
                    n_err++;
                    $display("FAIL accept_spacing: got %0d cycles, required >= 10",
                             acc_cyc - prev_acc);
                end
            end
            prev_acc = acc_cyc;
        end

        // Drain: every queued product must come out exactly once.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
